mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NCPU, default 2, giving the number of CPUs sharing the RAM port (1..4).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port iREN  input  NCPU  per-CPU instruction read request from icache.
REQ-005 The block SHALL have port iaddr  input  NCPU x 32  per-CPU instruction address.
REQ-006 The block SHALL have port iwait  output  NCPU  per-CPU instruction stall; low = iload valid this cycle.
REQ-007 The block SHALL have port iload  output  NCPU x 32  per-CPU instruction read data.
REQ-008 The block SHALL have ports dREN, dWEN  input  NCPU each  per-CPU data read and write requests.
REQ-009 The block SHALL have ports daddr, dstore  input  NCPU x 32 each  per-CPU data address and write data.
REQ-010 The block SHALL have ports dwait  output  NCPU and dload  output  NCPU x 32  data stall and read data.
REQ-011 The block SHALL have ports ramREN, ramWEN  output  1, ramaddr, ramstore  output  32  to the single RAM port.
REQ-012 The block SHALL have ports ramload  input  32 and ramstate  input  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-013 FSM states SHALL be IDLE, GRANT, DONE.
REQ-014 IDLE: any pending request SHALL select a winner and move to GRANT next cycle; no request stays IDLE.
REQ-015 Selection SHALL prefer data (dWEN or dREN) over instruction requests; within a class, order per REQ-026.
REQ-016 If a CPU asserts dREN and dWEN together, the write SHALL win and the read is ignored.
REQ-017 GRANT: winner's address (and dstore on write) SHALL drive ramaddr/ramstore with ramREN or ramWEN high; all other RAM outputs zero.
REQ-018 GRANT with ramstate==ACCESS: winner's wait SHALL drop combinationally that cycle, its load = ramload (read), FSM to DONE.
REQ-019 GRANT with BUSY or FREE: hold; with ERROR: hold and keep re-driving (retry).
REQ-020 GRANT with winner's request dropped: abort to IDLE next cycle, wait stays high, arbitration pointer unchanged.
REQ-021 DONE: one bubble cycle, no RAM strobe, all waits high, then IDLE; guarantees requester sees one-cycle ack.
REQ-022 Every wait output SHALL be high except the single grant acknowledge cycle; every load output zero except the acknowledged one.
REQ-023 Minimum latency request-to-ack SHALL be 2 cycles (IDLE sample, GRANT with ACCESS).
REQ-024 Winner index and class SHALL be registered on entry to GRANT and stay fixed for the transaction.

Reset
REQ-025 RST high on a clock edge SHALL force IDLE, pointer to CPU0, ramREN/ramWEN=0, ramaddr/ramstore=0, all waits=1, all loads=0, including mid-GRANT (transaction dropped, no ack).

Configuration
REQ-026 With ARB_RR_EN defined, each class SHALL use a round-robin pointer advanced past the winner on every ack; undefined, lowest CPU index SHALL always win.

Structure
REQ-027 ramstate_t, word_t, and the arb_state_t enum SHALL live in cpu_types_pkg.
REQ-028 A sub-module rr_pick (request vector + pointer -> one-hot grant) SHALL implement selection, instantiated once per class.

Verification
REQ-029 CPU0 iREN, iaddr=0x40, ramstate ACCESS in first GRANT with ramload=0x2400_0001 -> iwait[0] low exactly one cycle 2 cycles after request, iload[0]=0x2400_0001.
REQ-030 CPU0 iREN and CPU1 dWEN same cycle, daddr=0x80, dstore=0xDEAD_BEEF -> ramWEN with 0x80/0xDEAD_BEEF first, then the instruction read.
REQ-031 ARB_RR_EN, both CPUs hold iREN for 4 acks -> grants alternate 0,1,0,1; without macro -> 0,0,0,0.
REQ-032 ramstate BUSY 3 cycles then ACCESS -> wait stays high 3 cycles, ack on 4th GRANT cycle; ERROR 2 cycles then ACCESS -> same address re-driven, single ack.
REQ-033 RST asserted mid-GRANT -> next cycle IDLE, ramREN=0, all waits high, no ack issued.
REQ-034 Winner drops dREN mid-GRANT -> IDLE next cycle, no ack, pointer unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory subsystem: RAM port handshake state,
// machine word, and the arbiter FSM state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: scans the request vector starting at ptr and
// returns a one-hot grant for the first requester found (all-zero if none).
module rr_pick #(
  parameter int NCPU = 2,
  parameter int PW   = (NCPU > 1) ? $clog2(NCPU) : 1
) (
  input  logic [NCPU-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NCPU-1:0] gnt
);

  // First requester at or after ptr, wrapping around, wins.
  always_comb begin : pick
    int          c;
    logic [PW-1:0] ci;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < NCPU; k++) begin
      c = int'(ptr) + k;
      if (c >= NCPU) c = c - NCPU;
      ci = PW'(c);
      if (!found && req[ci]) begin
        gnt[ci] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for NCPU CPUs. Data requests beat instruction
// requests; a transaction runs IDLE -> GRANT -> DONE with a one-cycle ack.
// Optional feature: define ARB_RR_EN for per-class round-robin priority;
// otherwise the lowest CPU index always wins within a class.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCPU = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCPU-1:0]      iREN,
  input  logic [NCPU*32-1:0]   iaddr,
  output logic [NCPU-1:0]      iwait,
  output logic [NCPU*32-1:0]   iload,
  input  logic [NCPU-1:0]      dREN,
  input  logic [NCPU-1:0]      dWEN,
  input  logic [NCPU*32-1:0]   daddr,
  input  logic [NCPU*32-1:0]   dstore,
  output logic [NCPU-1:0]      dwait,
  output logic [NCPU*32-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate
);

  localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;

  arb_state_t    state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          isd_q, isd_d;
  logic          wr_q, wr_d;
  logic [PW-1:0] iptr, dptr;

  logic [NCPU-1:0] dreq, ignt, dgnt, sel_gnt;
  logic [PW-1:0]   sel_idx;
  logic            held, ack;
  word_t           ia [NCPU];
  word_t           da [NCPU];
  word_t           ds [NCPU];

  for (genvar g = 0; g < NCPU; g++) begin : g_unpack
    assign ia[g] = iaddr[g*32 +: 32];
    assign da[g] = daddr[g*32 +: 32];
    assign ds[g] = dstore[g*32 +: 32];
  end

  assign dreq = dREN | dWEN;

  rr_pick #(.NCPU(NCPU), .PW(PW)) u_pick_d (.req(dreq), .ptr(dptr), .gnt(dgnt));
  rr_pick #(.NCPU(NCPU), .PW(PW)) u_pick_i (.req(iREN), .ptr(iptr), .gnt(ignt));

  // Data class has priority; encode the chosen one-hot grant to an index.
  always_comb begin
    sel_gnt = (|dreq) ? dgnt : ignt;
    sel_idx = '0;
    for (int i = 0; i < NCPU; i++) begin
      if (sel_gnt[i]) sel_idx = PW'(i);
    end
  end

  // Whether the registered winner is still asserting the request it won with.
  always_comb begin
    if (isd_q) held = wr_q ? dWEN[idx_q] : dREN[idx_q];
    else       held = iREN[idx_q];
  end

  // FSM next state and winner capture on entry to GRANT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    isd_d   = isd_q;
    wr_d    = wr_q;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|dreq) || (|iREN)) begin
          state_d = GRANT;
          idx_d   = sel_idx;
          isd_d   = |dreq;
          wr_d    = (|dreq) & dWEN[sel_idx];
        end
      end
      GRANT: begin
        if (!held) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          ack     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_RR_EN
  logic [PW-1:0] iptr_q, iptr_d, dptr_q, dptr_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (int'(p) == NCPU - 1) return '0;
    return p + 1'b1;
  endfunction

  // Advance the acknowledged class's pointer just past the winner.
  always_comb begin
    iptr_d = iptr_q;
    dptr_d = dptr_q;
    if (ack) begin
      if (isd_q) dptr_d = ptr_next(idx_q);
      else       iptr_d = ptr_next(idx_q);
    end
  end

  // Round-robin pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iptr_q <= '0;
      dptr_q <= '0;
    end else begin
      iptr_q <= iptr_d;
      dptr_q <= dptr_d;
    end
  end

  assign iptr = iptr_q;
  assign dptr = dptr_q;
`else
  assign iptr = '0;
  assign dptr = '0;
`endif

  // FSM state register; an in-flight transaction is simply dropped on reset.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Winner registers are only consulted in GRANT, which always follows a capture.
  always_ff @(posedge CLK) begin
    idx_q <= idx_d;
    isd_q <= isd_d;
    wr_q  <= wr_d;
  end

  // RAM strobes while the winner holds its request; waits/loads carry the ack.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (state_q == GRANT && held) begin
      if (isd_q) begin
        ramaddr = da[idx_q];
        if (wr_q) begin
          ramWEN   = 1'b1;
          ramstore = ds[idx_q];
        end else begin
          ramREN = 1'b1;
        end
      end else begin
        ramaddr = ia[idx_q];
        ramREN  = 1'b1;
      end
    end
    for (int i = 0; i < NCPU; i++) begin
      if (ack && PW'(i) == idx_q) begin
        if (isd_q) begin
          dwait[i] = 1'b0;
          if (!wr_q) dload[i*32 +: 32] = ramload;
        end else begin
          iwait[i]           = 1'b0;
          iload[i*32 +: 32]  = ramload;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with NCPU=2; expectations follow ARB_RR_EN.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int NCPU = 2;

  logic              CLK;
  logic              RST;
  logic [NCPU-1:0]   iREN;
  logic [NCPU*32-1:0] iaddr;
  logic [NCPU-1:0]   iwait;
  logic [NCPU*32-1:0] iload;
  logic [NCPU-1:0]   dREN;
  logic [NCPU-1:0]   dWEN;
  logic [NCPU*32-1:0] daddr;
  logic [NCPU*32-1:0] dstore;
  logic [NCPU-1:0]   dwait;
  logic [NCPU*32-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [31:0]       ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  ramstate_t         ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.NCPU(NCPU)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [1:0]  exp_wait;
    int          widx;

    RST = 1'b1; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    check_val("rst_iwait",   iwait,   2'b11);
    check_val("rst_dwait",   dwait,   2'b11);
    check_val("rst_ramREN",  ramREN,  1'b0);
    check_val("rst_ramWEN",  ramWEN,  1'b0);
    check_val("rst_ramaddr", ramaddr, 32'h0);
    check_val("rst_ramstore", ramstore, 32'h0);
    check_val("rst_iload",   iload,   64'h0);
    check_val("rst_dload",   dload,   64'h0);
    RST = 1'b0;
    tick();

    // Basic instruction fetch, ack two cycles after request
    iREN = 2'b01; iaddr[31:0] = 32'h40;
    #1 check_val("if_req_cycle_wait", iwait, 2'b11);
    tick();
    ramstate = ACCESS; ramload = 32'h2400_0001;
    #1;
    check_val("if_ramREN",  ramREN,  1'b1);
    check_val("if_ramaddr", ramaddr, 32'h40);
    check_val("if_iwait",   iwait,   2'b10);
    check_val("if_iload",   iload,   {32'h0, 32'h2400_0001});
    check_val("if_dwait",   dwait,   2'b11);
    tick();
    iREN = '0; ramstate = FREE;
    #1;
    check_val("if_done_iwait",  iwait,  2'b11);
    check_val("if_done_ramREN", ramREN, 1'b0);
    check_val("if_done_iload",  iload,  64'h0);
    tick();
    check_val("if_idle_iwait", iwait, 2'b11);

    // Data write beats instruction read; write beats read on same CPU
    iREN = 2'b01; iaddr[31:0] = 32'h100;
    dREN = 2'b10; dWEN = 2'b10; daddr[63:32] = 32'h80; dstore[63:32] = 32'hDEAD_BEEF;
    tick();
    ramstate = ACCESS; ramload = 32'h5555_5555;
    #1;
    check_val("wr_ramWEN",   ramWEN,   1'b1);
    check_val("wr_ramREN",   ramREN,   1'b0);
    check_val("wr_ramaddr",  ramaddr,  32'h80);
    check_val("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    check_val("wr_dwait",    dwait,    2'b01);
    check_val("wr_dload",    dload,    64'h0);
    check_val("wr_iwait",    iwait,    2'b11);
    tick();
    dREN = '0; dWEN = '0; ramstate = FREE;
    #1;
    check_val("wr_done_dwait",  dwait,  2'b11);
    check_val("wr_done_ramWEN", ramWEN, 1'b0);
    tick();
    tick();
    ramstate = ACCESS; ramload = 32'h0000_1111;
    #1;
    check_val("if2_ramREN",  ramREN,  1'b1);
    check_val("if2_ramaddr", ramaddr, 32'h100);
    check_val("if2_iwait",   iwait,   2'b10);
    check_val("if2_iload",   iload,   {32'h0, 32'h0000_1111});
    tick();
    iREN = '0; ramstate = FREE;
    tick();

    // BUSY for three GRANT cycles, then ACCESS
    dREN = 2'b01; daddr[31:0] = 32'h200;
    tick();
    ramstate = BUSY;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("busy%0d_dwait", k), dwait, 2'b11);
      check_val($sformatf("busy%0d_ramREN", k), ramREN, 1'b1);
      check_val($sformatf("busy%0d_ramaddr", k), ramaddr, 32'h200);
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFE_0000;
    #1;
    check_val("busy_ack_dwait", dwait, 2'b10);
    check_val("busy_ack_dload", dload, {32'h0, 32'hCAFE_0000});
    tick();
    dREN = '0; ramstate = FREE;
    #1 check_val("busy_done_dwait", dwait, 2'b11);
    tick();

    // ERROR twice: same address re-driven, single ack
    dREN = 2'b10; daddr[63:32] = 32'h300;
    tick();
    ramstate = ERROR;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_val($sformatf("err%0d_ramaddr", k), ramaddr, 32'h300);
      check_val($sformatf("err%0d_ramREN", k), ramREN, 1'b1);
      check_val($sformatf("err%0d_dwait", k), dwait, 2'b11);
      tick();
    end
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    #1;
    check_val("err_ack_dwait", dwait, 2'b01);
    check_val("err_ack_dload", dload, {32'h0BAD_F00D, 32'h0});
    tick();
    #1 check_val("err_done_dwait", dwait, 2'b11);
    dREN = '0; ramstate = FREE;
    tick();

    // Two CPUs fetching continuously: grant order depends on ARB_RR_EN
    RST = 1'b1; tick(); RST = 1'b0;
    iREN = 2'b11; iaddr = {32'h14, 32'h10};
    for (int a = 0; a < 4; a++) begin
`ifdef ARB_RR_EN
      widx = a % 2;
`else
      widx = 0;
`endif
      exp_addr = (widx == 1) ? 32'h14 : 32'h10;
      exp_wait = (widx == 1) ? 2'b01 : 2'b10;
      tick();
      ramstate = ACCESS;
      #1;
      check_val($sformatf("rr%0d_ramaddr", a), ramaddr, exp_addr);
      check_val($sformatf("rr%0d_iwait", a), iwait, exp_wait);
      tick();
      ramstate = FREE;
      tick();
    end
    iREN = '0;
    tick();

    // Reset in the middle of a GRANT drops the transaction
    iREN = 2'b10;
    tick();
    ramstate = BUSY;
    #1;
    check_val("mrst_pre_ramREN",  ramREN,  1'b1);
    check_val("mrst_pre_ramaddr", ramaddr, 32'h14);
    RST = 1'b1;
    tick();
    ramstate = ACCESS;
    #1;
    check_val("mrst_ramREN",  ramREN,  1'b0);
    check_val("mrst_iwait",   iwait,   2'b11);
    check_val("mrst_ramaddr", ramaddr, 32'h0);
    RST = 1'b0; iREN = '0; ramstate = FREE;
    tick();

    // Winner drops its read mid-GRANT: abort without ack, pointer kept
    dREN = 2'b11; daddr = {32'h300, 32'h200};
    tick();
    ramstate = BUSY;
    #1 check_val("drop_pre_ramaddr", ramaddr, 32'h200);
    dREN = 2'b10; ramstate = ACCESS;
    #1;
    check_val("drop_dwait",  dwait,  2'b11);
    check_val("drop_ramREN", ramREN, 1'b0);
    tick();
    check_val("drop_idle_dwait",  dwait,  2'b11);
    check_val("drop_idle_ramREN", ramREN, 1'b0);
    dREN = 2'b11;
    tick();
    #1;
    check_val("drop_regrant_ramaddr", ramaddr, 32'h200);
    check_val("drop_regrant_dwait",   dwait,   2'b10);
    tick();
    dREN = '0; ramstate = FREE;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
